// File: rtl/mod_up_down_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear, clamped parallel
// load, count enable and wrap/saturate selection. Reports terminal events
// as a one-cycle registered pulse (wrap) plus a sticky flag (ovf).
module mod_up_down_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic             at_min,
    output logic             at_max,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] next_out;
    logic             next_wrap;
    logic             next_ovf;

    // Terminal flags decode straight from the registered count.
    always_comb begin
        at_min = (out == '0);
        at_max = (out == MAX_V);
    end

    // Next-state selection in priority order clr > load > en > hold.
    // The count is compared against MAX before stepping, so a non-power-of-two
    // modulus can never produce a value above MAX.
    always_comb begin
        next_out  = out;
        next_wrap = 1'b0;
        next_ovf  = ovf;
        if (clr) begin
            next_out = '0;
            next_ovf = 1'b0;
        end else if (load) begin
            next_out = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (!dir) begin
                if (out == MAX_V) begin
                    next_out  = SATURATE ? MAX_V : '0;
                    next_wrap = 1'b1;
                    next_ovf  = 1'b1;
                end else begin
                    next_out = out + WIDTH'(1);
                end
            end else begin
                if (out == '0) begin
                    next_out  = SATURATE ? '0 : MAX_V;
                    next_wrap = 1'b1;
                    next_ovf  = 1'b1;
                end else begin
                    next_out = out - WIDTH'(1);
                end
            end
        end
    end

    // State registers; reset clears everything immediately, cutting any pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            out  <= next_out;
            wrap <= next_wrap;
            ovf  <= next_ovf;
        end
    end

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Directed checks for mod_up_down_counter: one wrapping and one saturating
// instance (both MAX=9) share the same stimulus.
module tb_mod_up_down_counter;

    logic       clk = 1'b0;
    logic       reset, clr, load, en, dir;
    logic [3:0] load_val;

    logic [3:0] w_out, s_out;
    logic       w_at_min, w_at_max, w_wrap, w_ovf;
    logic       s_at_min, s_at_max, s_wrap, s_ovf;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mod_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .out(w_out), .at_min(w_at_min), .at_max(w_at_max),
        .wrap(w_wrap), .ovf(w_ovf)
    );

    mod_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .out(s_out), .at_min(s_at_min), .at_max(s_at_max),
        .wrap(s_wrap), .ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; load_val = '0;
        #3;
        check("rst_out",    32'(w_out),    0);
        check("rst_at_min", 32'(w_at_min), 1);
        check("rst_at_max", 32'(w_at_max), 0);
        check("rst_wrap",   32'(w_wrap),   0);
        check("rst_ovf",    32'(w_ovf),    0);
        reset = 1'b0;

        // 1: count up across the modulus
        en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("t1_out",  32'(w_out),  32'(i % 10));
            check("t1_wrap", 32'(w_wrap), (i == 10) ? 1 : 0);
            check("t1_ovf",  32'(w_ovf),  (i >= 10) ? 1 : 0);
        end

        // 2: count down from reset; saturating instance sticks at 0
        pulse_reset();
        check("t2_rst_ovf", 32'(w_ovf), 0);
        dir = 1'b1;
        step();
        check("t2_out0",    32'(w_out),    9);
        check("t2_wrap0",   32'(w_wrap),   1);
        check("t2_atmax0",  32'(w_at_max), 1);
        check("t2_s_out0",  32'(s_out),    0);
        check("t2_s_wrap0", 32'(s_wrap),   1);
        check("t2_s_ovf0",  32'(s_ovf),    1);
        step();
        check("t2_out1",    32'(w_out),    8);
        check("t2_wrap1",   32'(w_wrap),   0);
        check("t2_atmax1",  32'(w_at_max), 0);
        step();
        check("t2_out2",    32'(w_out),    7);

        // 3: saturate at MAX
        en = 1'b0; load = 1'b1; load_val = 4'd8;
        step();
        check("t3_load", 32'(s_out), 8);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        step();
        check("t3_out0",  32'(s_out),  9);
        check("t3_wrap0", 32'(s_wrap), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t3_out",   32'(s_out),    9);
            check("t3_wrap",  32'(s_wrap),   1);
            check("t3_atmax", 32'(s_at_max), 1);
        end
        dir = 1'b1;
        step();
        check("t3_down_out",  32'(s_out),  8);
        check("t3_down_wrap", 32'(s_wrap), 0);

        // 4: load clamp, clr over load, load over en
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        step();
        check("t4_clamp_w",  32'(w_out),  9);
        check("t4_clamp_s",  32'(s_out),  9);
        check("t4_keep_ovf", 32'(s_ovf),  1);
        check("t4_ld_wrap",  32'(s_wrap), 0);
        clr = 1'b1; load_val = 4'd5;
        step();
        check("t4_clr_out", 32'(w_out), 0);
        check("t4_clr_ovf", 32'(w_ovf), 0);
        check("t4_clr_sovf", 32'(s_ovf), 0);
        clr = 1'b0; en = 1'b1; dir = 1'b0; load_val = 4'd4;
        step();
        check("t4_ld_en_w", 32'(w_out), 4);
        check("t4_ld_en_s", 32'(s_out), 4);
        load = 1'b0;

        // 5: asynchronous reset mid-count
        pulse_reset();
        for (int i = 1; i <= 6; i++) step();
        check("t5_pre", 32'(w_out), 6);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_out",  32'(w_out),    0);
        check("t5_async_min",  32'(w_at_min), 1);
        check("t5_async_wrap", 32'(w_wrap),   0);
        check("t5_async_ovf",  32'(w_ovf),    0);
        #1;
        reset = 1'b0;
        step();
        check("t5_first", 32'(w_out), 1);

        // 6: hold, then direction toggling every cycle
        for (int i = 1; i <= 4; i++) step();
        check("t6_pre", 32'(w_out), 5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold",      32'(w_out),  5);
            check("t6_hold_wrap", 32'(w_wrap), 0);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir = (i % 2 == 1);
            step();
            check("t6_toggle", 32'(w_out), (i % 2 == 0) ? 6 : 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
